div_rate_ctrl: RTL and testbench

Owns one free-running prescaler counter and schedules the divided-clock rate taken from it.
- Produces a one-cycle clock-enable tick and a square wave at a selectable rate of clk/2, /4, /8 or /16.
- Accepts rate-change requests over a req/ack handshake.
- Applies a new rate only at the counter's common wrap point, so neither tick nor div_out ever shows a truncated period.
- Sits between the top-level IO pins and any logic clocked by divided rates; it replaces ripple-clocked divider flops with enables on the single clk.

---
 rtl/div_rate_ctrl.sv | 102 ++++++++++
 tb/tb_div_rate_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/div_rate_ctrl.sv
// div_rate_ctrl: a single free-running prescaler that yields a clock-enable tick
// and a 50% square wave at clk/2, /4, /8 or /16. Rate changes arrive over a
// req/ack handshake and are applied only at the counter's common wrap point,
// so no output period is ever truncated.
module div_rate_ctrl #(
    parameter int CNT_W     = 4,
    parameter int MAX_SEL   = 3,
    parameter int RESET_SEL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rate_req,
    input  logic [2:0] rate_sel,
    output logic       rate_ack,
    output logic       rate_err,
    output logic       busy,
    output logic [2:0] cur_sel,
    output logic       tick,
    output logic       div_out
);

    localparam int SEL_W = 3;

    // Two-state handshake FSM.
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PENDING = 1'b1;

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pend_sel;
    logic [CNT_W-1:0] bit_sel;
    logic [CNT_W-1:0] period_mask;
    logic             wrap;

    // Decode the active rate into the counter bit that drives div_out and the
    // low-bit mask whose all-ones value marks the end of a period.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned, which would infer a latch.
        bit_sel     = '0;
        period_mask = '0;
        bit_sel     = CNT_W'(1) << cur_sel;
        period_mask = bit_sel | (bit_sel - CNT_W'(1));
    end

    assign tick    = ena & ((cnt & period_mask) == period_mask);
    assign div_out = |(cnt & bit_sel);
    assign busy    = (state == ST_PENDING);

    // The all-ones count is a period boundary for every legal rate, so it is
    // the only safe point to swap rates.
    assign wrap = ena & (cnt == {CNT_W{1'b1}});

    // Free-running prescaler; holds while ena is low and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Request handshake: accept legal codes in IDLE, flag illegal ones, and
    // commit the pending code at the next enabled wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cur_sel  <= SEL_W'(RESET_SEL);
            pend_sel <= SEL_W'(RESET_SEL);
            rate_ack <= 1'b0;
            rate_err <= 1'b0;
        end else begin
            rate_ack <= 1'b0;
            rate_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rate_req) begin
                        if (rate_sel <= SEL_W'(MAX_SEL)) begin
                            pend_sel <= rate_sel;
                            state    <= ST_PENDING;
                        end else begin
                            rate_err <= 1'b1;
                        end
                    end
                end
                ST_PENDING: begin
                    // New requests are ignored here, including on the switch edge.
                    if (wrap) begin
                        cur_sel  <= pend_sel;
                        rate_ack <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rate_ctrl.sv
// Self-checking bench for div_rate_ctrl. A behavioural model advances alongside
// the DUT; each driven cycle pushes the expected post-edge outputs to a queue,
// which is popped and compared just after the clock edge.
module tb_div_rate_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       rate_req;
    logic [2:0] rate_sel;
    logic       rate_ack;
    logic       rate_err;
    logic       busy;
    logic [2:0] cur_sel;
    logic       tick;
    logic       div_out;

    div_rate_ctrl #(.CNT_W(4), .MAX_SEL(3), .RESET_SEL(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .rate_req (rate_req),
        .rate_sel (rate_sel),
        .rate_ack (rate_ack),
        .rate_err (rate_err),
        .busy     (busy),
        .cur_sel  (cur_sel),
        .tick     (tick),
        .div_out  (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       div_out;
        logic       ack;
        logic       err;
        logic       busy;
        logic [2:0] cur;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (values after the most recent clock edge).
    int m_cnt;
    int m_cur;
    int m_pend;
    bit m_pending;
    bit m_ack;
    bit m_err;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_cur     = 0;
        m_pend    = 0;
        m_pending = 0;
        m_ack     = 0;
        m_err     = 0;
        sb.delete();
    endtask

    task automatic model_step(input bit e, input bit r, input int s);
        m_ack = 0;
        m_err = 0;
        if (m_pending) begin
            if (e && m_cnt == 15) begin
                m_cur     = m_pend;
                m_ack     = 1;
                m_pending = 0;
            end
        end else if (r) begin
            if (s <= 3) begin
                m_pend    = s;
                m_pending = 1;
            end else begin
                m_err = 1;
            end
        end
        if (e) m_cnt = (m_cnt + 1) % 16;
    endtask

    // Drive one cycle of inputs, predict, then compare just after the edge.
    task automatic cycle(input bit e, input bit r, input int s);
        exp_t x;
        int   per;
        ena      = e;
        rate_req = r;
        rate_sel = 3'(s);
        model_step(e, r, s);
        per       = 2 << m_cur;
        x.tick    = e && (((m_cnt + 1) % per) == 0);
        x.div_out = (m_cnt % per) >= (per / 2);
        x.ack     = m_ack;
        x.err     = m_err;
        x.busy    = m_pending;
        x.cur     = 3'(m_cur);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("tick",    {7'd0, tick},     {7'd0, x.tick});
        check("div_out", {7'd0, div_out},  {7'd0, x.div_out});
        check("ack",     {7'd0, rate_ack}, {7'd0, x.ack});
        check("err",     {7'd0, rate_err}, {7'd0, x.err});
        check("busy",    {7'd0, busy},     {7'd0, x.busy});
        check("cur_sel", {5'd0, cur_sel},  {5'd0, x.cur});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0);
    endtask

    task automatic run_to_cnt(input int c);
        for (int i = 0; i < 40 && m_cnt != c; i++) cycle(1, 0, 0);
        check("reach_cnt", 8'(m_cnt), 8'(c));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tick"}, {7'd0, tick},     8'd0);
        check({tag, "_div"},  {7'd0, div_out},  8'd0);
        check({tag, "_ack"},  {7'd0, rate_ack}, 8'd0);
        check({tag, "_err"},  {7'd0, rate_err}, 8'd0);
        check({tag, "_busy"}, {7'd0, busy},     8'd0);
        check({tag, "_cur"},  {5'd0, cur_sel},  8'd0);
    endtask

    initial begin
        rst_n    = 1'b1;
        ena      = 1'b0;
        rate_req = 1'b0;
        rate_sel = 3'd0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("rst0");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle at /2: tick every 2 cycles, div_out alternates.
        cycle(0, 0, 0);
        run(8);

        // Switch to /16 requested at cnt=5; old ticks run through cnt=15.
        run_to_cnt(5);
        cycle(1, 1, 3);
        run(40);

        // Illegal codes flag rate_err and change nothing else.
        cycle(1, 1, 5);
        run(3);
        cycle(1, 1, 7);
        run(3);

        // Second request while pending is ignored; only code 2 is applied.
        cycle(1, 1, 2);
        for (int i = 0; i < 6; i++) cycle(1, 1, 1);
        run(30);

        // Request equal to the active code: waits for the wrap, waveform unchanged.
        cycle(1, 1, 2);
        run(24);

        // ena dropped at cnt=14 while pending stalls the switch.
        run_to_cnt(12);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        check("stall_cnt", 8'(m_cnt), 8'd14);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);
        run(12);

        // Go to /16, then reset asynchronously while a change to code 1 is pending.
        cycle(1, 1, 3);
        run(20);
        cycle(1, 1, 1);
        run(3);
        check("pre_rst_busy", {7'd0, busy}, 8'd1);
        check("pre_rst_cur", {5'd0, cur_sel}, 8'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst1");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
